// File: rtl/matrix_ram_loader.sv
// Byte-stream loader for the matrix RAM: packs 25-byte matrices A and B into
// consecutive RAM words at BASE_ADDR and BASE_ADDR+1.
module matrix_ram_loader #(
    parameter int ELEM_WIDTH = 8,
    parameter int ELEM_COUNT = 25,
    parameter int RAM_WIDTH  = 256,
    parameter int ADDR_WIDTH = 8,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic [ELEM_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [RAM_WIDTH-1:0]  ram_data,
    output logic                  ram_wren,
    output logic                  loading_b,
    output logic [4:0]            elem_count,
    output logic                  load_done
);

    localparam int PACK_W = ELEM_WIDTH * ELEM_COUNT;
    localparam logic [4:0] LAST_ELEM = 5'(ELEM_COUNT - 1);

    typedef enum logic [2:0] {
        FILL_A,
        WRITE_A,
        FILL_B,
        WRITE_B,
        DONE
    } state_t;

    state_t                state, next_state;
    logic [PACK_W-1:0]     pack, next_pack;
    logic [4:0]            next_count;
    logic                  next_loading_b;
    logic [RAM_WIDTH-1:0]  next_word;
    logic                  fire;

    assign fire = in_valid && in_ready;

    always_comb begin
        next_state     = state;
        next_pack      = pack;
        next_count     = elem_count;
        next_loading_b = loading_b;

        case (state)
            FILL_A, FILL_B: begin
                if (clear) begin
                    next_state     = FILL_A;
                    next_pack      = '0;
                    next_count     = '0;
                    next_loading_b = 1'b0;
                end else if (fire) begin
                    for (int unsigned k = 0; k < ELEM_COUNT; k++) begin
                        if (elem_count == 5'(k)) begin
                            next_pack[ELEM_WIDTH*k +: ELEM_WIDTH] = in_data;
                        end
                    end
                    if (elem_count == LAST_ELEM) begin
                        next_count = '0;
                        next_state = (state == FILL_A) ? WRITE_A : WRITE_B;
                    end else begin
                        next_count = elem_count + 5'd1;
                    end
                end
            end
            WRITE_A: begin
                // The write itself is already on the bus; a clear here only redirects what follows.
                next_pack = '0;
                if (clear) begin
                    next_state     = FILL_A;
                    next_loading_b = 1'b0;
                end else begin
                    next_state     = FILL_B;
                    next_loading_b = 1'b1;
                end
            end
            WRITE_B: begin
                if (clear) begin
                    next_state     = FILL_A;
                    next_pack      = '0;
                    next_loading_b = 1'b0;
                end else begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state     = FILL_A;
                next_pack      = '0;
                next_count     = '0;
                next_loading_b = 1'b0;
            end
            default: begin
                next_state     = FILL_A;
                next_pack      = '0;
                next_count     = '0;
                next_loading_b = 1'b0;
            end
        endcase

        next_word               = '0;
        next_word[PACK_W-1:0]   = next_pack;
    end

    // Outputs are registered decodes of the state being entered.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= FILL_A;
            pack        <= '0;
            elem_count  <= '0;
            loading_b   <= 1'b0;
            in_ready    <= 1'b0;
            ram_wren    <= 1'b0;
            ram_address <= ADDR_WIDTH'(BASE_ADDR);
            ram_data    <= '0;
            load_done   <= 1'b0;
        end else begin
            state      <= next_state;
            pack       <= next_pack;
            elem_count <= next_count;
            loading_b  <= next_loading_b;
            in_ready   <= (next_state == FILL_A) || (next_state == FILL_B);
            ram_wren   <= (next_state == WRITE_A) || (next_state == WRITE_B);
            load_done  <= (next_state == DONE);
            if (next_state == WRITE_A) begin
                ram_address <= ADDR_WIDTH'(BASE_ADDR);
                ram_data    <= next_word;
            end else if (next_state == WRITE_B) begin
                ram_address <= ADDR_WIDTH'(BASE_ADDR + 1);
                ram_data    <= next_word;
            end
        end
    end

endmodule

// File: tb/tb_matrix_ram_loader.sv
// Self-checking bench for matrix_ram_loader: table-driven loads with random
// valid gaps, plus clear/reset corner sequences against a byte-queue model.
module tb_matrix_ram_loader;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         clear = 1'b0;
    logic [7:0]   in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [7:0]   ram_address;
    logic [255:0] ram_data;
    logic         ram_wren;
    logic         loading_b;
    logic [4:0]   elem_count;
    logic         load_done;

    matrix_ram_loader #(
        .ELEM_WIDTH(8),
        .ELEM_COUNT(25),
        .RAM_WIDTH (256),
        .ADDR_WIDTH(8),
        .BASE_ADDR (0)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .clear      (clear),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ram_address(ram_address),
        .ram_data   (ram_data),
        .ram_wren   (ram_wren),
        .loading_b  (loading_b),
        .elem_count (elem_count),
        .load_done  (load_done)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    logic [255:0] mem [4];
    int           acc_q[$];
    int           wren_q[$];
    int           done_q[$];
    int           viol = 0;
    logic         prev_wren = 1'b0;
    logic [7:0]   tx[$];

    // Passive RAM model and protocol watchdog, sampled mid-cycle.
    always @(negedge clock) begin
        if (!reset) begin
            if (in_valid && in_ready && !clear) acc_q.push_back(cyc);
            if (ram_wren) begin
                wren_q.push_back(cyc);
                mem[ram_address[1:0]] = ram_data;
                if (ram_address > 8'd1) viol++;
            end
            if (load_done) done_q.push_back(cyc);
            if (elem_count > 5'd24) viol++;
            if (ram_wren && prev_wren) viol++;
            if (ram_wren && in_ready) viol++;
        end
        prev_wren = ram_wren;
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_log();
        acc_q.delete();
        wren_q.delete();
        done_q.delete();
        viol = 0;
        for (int i = 0; i < 4; i++) mem[i] = '1;
    endtask

    task automatic fill_tx(input int n, input bit rnd, input int first);
        tx.delete();
        for (int i = 0; i < n; i++) tx.push_back(rnd ? 8'($urandom) : 8'(first + i));
    endtask

    function automatic logic [255:0] word_of(input int off);
        logic [255:0] w;
        w = '0;
        for (int k = 0; k < 25; k++) w[8*k +: 8] = tx[off + k];
        return w;
    endfunction

    // Offers tx[0..n-1] in order; a byte advances only when the handshake completes.
    task automatic stream(input int duty, input int n);
        int  sent  = 0;
        int  guard = 0;
        bit  fire;
        while (sent < n && guard < 3000) begin
            in_valid = ($urandom_range(99) < duty);
            in_data  = tx[sent];
            @(negedge clock);
            fire = in_valid && in_ready;
            @(posedge clock);
            #1;
            if (fire) sent++;
            guard++;
        end
        in_valid = 1'b0;
        if (sent < n) begin
            tests++;
            fails++;
            $display("FAIL stream_timeout: sent %0d required %0d", sent, n);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check_full_load(input string tag, input int off);
        check({tag, "_wren_count"}, 256'(wren_q.size()), 256'(2));
        check({tag, "_done_count"}, 256'(done_q.size()), 256'(1));
        check({tag, "_word0"}, mem[0], word_of(off));
        check({tag, "_word1"}, mem[1], word_of(off + 25));
        check({tag, "_protocol_violations"}, 256'(viol), 256'(0));
    endtask

    typedef struct {
        int duty;
        bit rnd;
        int exp_wren;
        int exp_done;
        int exp_accepted;
    } vec_t;

    vec_t vecs[4];

    initial begin
        vecs[0] = '{duty: 100, rnd: 1'b0, exp_wren: 2, exp_done: 1, exp_accepted: 50};
        vecs[1] = '{duty: 50,  rnd: 1'b0, exp_wren: 2, exp_done: 1, exp_accepted: 50};
        vecs[2] = '{duty: 50,  rnd: 1'b1, exp_wren: 2, exp_done: 1, exp_accepted: 50};
        vecs[3] = '{duty: 25,  rnd: 1'b1, exp_wren: 2, exp_done: 1, exp_accepted: 50};

        // Reset values
        clear_log();
        repeat (2) @(posedge clock);
        #1;
        check("rst_in_ready", 256'(in_ready), 256'(0));
        check("rst_ram_wren", 256'(ram_wren), 256'(0));
        check("rst_ram_address", 256'(ram_address), 256'(0));
        check("rst_ram_data", ram_data, '0);
        check("rst_loading_b", 256'(loading_b), 256'(0));
        check("rst_elem_count", 256'(elem_count), 256'(0));
        check("rst_load_done", 256'(load_done), 256'(0));
        reset = 1'b0;
        idle(1);
        check("rst_release_in_ready", 256'(in_ready), 256'(1));

        // Table-driven full loads
        for (int v = 0; v < 4; v++) begin
            clear_log();
            fill_tx(50, vecs[v].rnd, 1);
            stream(vecs[v].duty, 50);
            idle(4);
            check($sformatf("vec%0d_accepted", v), 256'(acc_q.size()), 256'(vecs[v].exp_accepted));
            check($sformatf("vec%0d_wren_count", v), 256'(wren_q.size()), 256'(vecs[v].exp_wren));
            check($sformatf("vec%0d_done_count", v), 256'(done_q.size()), 256'(vecs[v].exp_done));
            check($sformatf("vec%0d_word0", v), mem[0], word_of(0));
            check($sformatf("vec%0d_word1", v), mem[1], word_of(25));
            check($sformatf("vec%0d_protocol", v), 256'(viol), 256'(0));
            if (acc_q.size() == 50 && wren_q.size() == 2 && done_q.size() == 1) begin
                check($sformatf("vec%0d_lat_wren_a", v), 256'(wren_q[0] - acc_q[24]), 256'(1));
                check($sformatf("vec%0d_lat_wren_b", v), 256'(wren_q[1] - acc_q[49]), 256'(1));
                check($sformatf("vec%0d_lat_done", v), 256'(done_q[0] - acc_q[49]), 256'(2));
                check($sformatf("vec%0d_gap_after_a", v), 256'(acc_q[25] - acc_q[24] >= 2), 256'(1));
            end
        end

        // Abort a partial load: byte 11 arrives together with clear
        clear_log();
        fill_tx(10, 1'b1, 0);
        stream(100, 10);
        in_valid = 1'b1;
        in_data  = 8'hEE;
        clear    = 1'b1;
        idle(1);
        clear    = 1'b0;
        in_valid = 1'b0;
        check("clr_elem_count", 256'(elem_count), 256'(0));
        check("clr_loading_b", 256'(loading_b), 256'(0));
        check("clr_in_ready", 256'(in_ready), 256'(1));
        check("clr_no_wren_aborted", 256'(wren_q.size()), 256'(0));
        fill_tx(50, 1'b1, 0);
        stream(60, 50);
        idle(4);
        check("clr_accepted", 256'(acc_q.size()), 256'(60));
        check_full_load("clr", 0);

        // clear during the WRITE_A cycle
        clear_log();
        fill_tx(25, 1'b1, 0);
        stream(100, 25);
        check("wa_in_write_cycle", 256'(ram_wren), 256'(1));
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
        check("wa_in_ready", 256'(in_ready), 256'(1));
        check("wa_loading_b", 256'(loading_b), 256'(0));
        check("wa_elem_count", 256'(elem_count), 256'(0));
        check("wa_word0_written", mem[0], word_of(0));
        check("wa_single_wren", 256'(wren_q.size()), 256'(1));
        clear_log();
        fill_tx(50, 1'b1, 0);
        stream(70, 50);
        idle(4);
        check_full_load("wa_reload", 0);

        // reset mid-load
        clear_log();
        fill_tx(30, 1'b1, 0);
        stream(100, 30);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        check("mid_rst_in_ready", 256'(in_ready), 256'(0));
        check("mid_rst_ram_wren", 256'(ram_wren), 256'(0));
        check("mid_rst_ram_address", 256'(ram_address), 256'(0));
        check("mid_rst_ram_data", ram_data, '0);
        check("mid_rst_loading_b", 256'(loading_b), 256'(0));
        check("mid_rst_elem_count", 256'(elem_count), 256'(0));
        check("mid_rst_load_done", 256'(load_done), 256'(0));
        idle(1);
        check("mid_rst_in_ready_after", 256'(in_ready), 256'(1));
        clear_log();
        fill_tx(50, 1'b1, 0);
        stream(50, 50);
        idle(4);
        check_full_load("mid_rst_reload", 0);

        // Scalar in B element 0, applied element-wise to A
        begin
            logic [255:0] got;
            logic [255:0] exp;
            clear_log();
            fill_tx(50, 1'b1, 0);
            tx[25] = 8'h03;
            stream(80, 50);
            idle(4);
            check("scalar_word1_lsb", 256'(mem[1][7:0]), 256'(8'h03));
            got = '0;
            exp = '0;
            for (int k = 0; k < 25; k++) begin
                got[8*k +: 8] = 8'(mem[1][7:0] * mem[0][8*k +: 8]);
                exp[8*k +: 8] = 8'(3 * tx[k]);
            end
            check("scalar_result", got, exp);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
